// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
// Holds the FSM state encoding, port indices and counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundles for the memory-port arbiter.
// arb_req_if: req/we/addr/wdata in, rdata/ack out (slave = arbiter side).
// arb_mem_if: en/we/addr/wdata out, rdata in (master = arbiter side).
interface arb_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

interface arb_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output en, we, addr, wdata, input rdata);
    modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// Ports: req[1:0], last_grant in; grant index, any_req out.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_req
);

    always_comb begin
        any_req = |req;
        grant   = PORT_CPU;
        unique case (1'b1)
            (req == 2'b11): grant = ~last_grant;
            (req == 2'b10): grant = PORT_DBG;
            default:        grant = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU (port 0) and debug loader (port 1).
// Ports: clock, rst, cpu/dbg requester bundles, mem bundle, busy.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic  clock,
    input  logic  rst,
    arb_req_if.slave  cpu,
    arb_req_if.slave  dbg,
    arb_mem_if.master mem,
    output logic  busy
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;

    logic              pick_gnt;
    logic              pick_any;

    rr_pick2 u_pick (
        .req        ({dbg.req, cpu.req}),
        .last_grant (last_q),
        .grant      (pick_gnt),
        .any_req    (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    we_d    = (pick_gnt == PORT_DBG) ? dbg.we : cpu.we;
                    addr_d  = (pick_gnt == PORT_DBG) ? dbg.addr : cpu.addr;
                    wdata_d = (pick_gnt == PORT_DBG) ? dbg.wdata : cpu.wdata;
                    // strobes are flopped so they line up with ISSUE
                    mem_en_d = 1'b1;
                    mem_we_d = we_d;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!we_q) begin
                        if (gnt_q == PORT_DBG) dbg_rdata_d = mem.rdata;
                        else                   cpu_rdata_d = mem.rdata;
                    end
                    // ack is flopped so it is high exactly in DONE
                    cpu_ack_d = (gnt_q == PORT_CPU);
                    dbg_ack_d = (gnt_q == PORT_DBG);
                    state_d   = DONE;
                end
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= PORT_CPU;
            last_q      <= PORT_DBG;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem.en    = mem_en_q;
    assign mem.we    = mem_we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
    assign cpu.rdata = cpu_rdata_q;
    assign cpu.ack   = cpu_ack_q;
    assign dbg.rdata = dbg_rdata_q;
    assign dbg.ack   = dbg_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 4) against
// a transaction-level timing model, directed cases then random traffic.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat [2];

    // stimulus [dut][port]
    logic        s_req   [2][2];
    logic        s_we    [2][2];
    logic [31:0] s_addr  [2][2];
    logic [31:0] s_wdata [2][2];
    logic [31:0] mem_rdata [2];

    logic        o_busy  [2];
    logic        o_en    [2];
    logic        o_we    [2];
    logic [31:0] o_addr  [2];
    logic [31:0] o_wdata [2];
    logic        o_ack   [2][2];
    logic [31:0] o_rdata [2][2];

    arb_req_if cpu_if0 ();
    arb_req_if dbg_if0 ();
    arb_mem_if mem_if0 ();
    arb_req_if cpu_if1 ();
    arb_req_if dbg_if1 ();
    arb_mem_if mem_if1 ();

    assign cpu_if0.req   = s_req[0][0];
    assign cpu_if0.we    = s_we[0][0];
    assign cpu_if0.addr  = s_addr[0][0];
    assign cpu_if0.wdata = s_wdata[0][0];
    assign dbg_if0.req   = s_req[0][1];
    assign dbg_if0.we    = s_we[0][1];
    assign dbg_if0.addr  = s_addr[0][1];
    assign dbg_if0.wdata = s_wdata[0][1];
    assign mem_if0.rdata = mem_rdata[0];
    assign cpu_if1.req   = s_req[1][0];
    assign cpu_if1.we    = s_we[1][0];
    assign cpu_if1.addr  = s_addr[1][0];
    assign cpu_if1.wdata = s_wdata[1][0];
    assign dbg_if1.req   = s_req[1][1];
    assign dbg_if1.we    = s_we[1][1];
    assign dbg_if1.addr  = s_addr[1][1];
    assign dbg_if1.wdata = s_wdata[1][1];
    assign mem_if1.rdata = mem_rdata[1];

    assign o_en[0]       = mem_if0.en;
    assign o_we[0]       = mem_if0.we;
    assign o_addr[0]     = mem_if0.addr;
    assign o_wdata[0]    = mem_if0.wdata;
    assign o_ack[0][0]   = cpu_if0.ack;
    assign o_ack[0][1]   = dbg_if0.ack;
    assign o_rdata[0][0] = cpu_if0.rdata;
    assign o_rdata[0][1] = dbg_if0.rdata;
    assign o_en[1]       = mem_if1.en;
    assign o_we[1]       = mem_if1.we;
    assign o_addr[1]     = mem_if1.addr;
    assign o_wdata[1]    = mem_if1.wdata;
    assign o_ack[1][0]   = cpu_if1.ack;
    assign o_ack[1][1]   = dbg_if1.ack;
    assign o_rdata[1][0] = cpu_if1.rdata;
    assign o_rdata[1][1] = dbg_if1.rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut0 (
        .clock (clk),
        .rst   (rst),
        .cpu   (cpu_if0),
        .dbg   (dbg_if0),
        .mem   (mem_if0),
        .busy  (o_busy[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut1 (
        .clock (clk),
        .rst   (rst),
        .cpu   (cpu_if1),
        .dbg   (dbg_if1),
        .mem   (mem_if1),
        .busy  (o_busy[1])
    );

    // transaction model: one record per DUT, start cycle t = grant cycle
    bit          m_valid;
    bit          m_act  [2];
    int          m_t    [2];
    bit          m_g    [2];
    bit          m_we   [2];
    bit          m_last [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata[2];
    logic [31:0] m_rdata[2][2];

    // bench memory bookkeeping
    int          issue_c [2];
    logic [31:0] issue_a [2];

    // event counters for directed checks
    int          ev_en   [2];
    int          ev_we   [2];
    int          ev_busy [2];
    int          ev_ack  [2][2];
    int          first_en  [2];
    int          first_ack [2][2];
    bit          ack_seen  [2][2];
    logic [31:0] en_log  [2][$];

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        if (a == 32'h30) return 32'h0000_1234;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic clr_ev();
        for (int k = 0; k < 2; k++) begin
            ev_en[k] = 0;
            ev_we[k] = 0;
            ev_busy[k] = 0;
            first_en[k] = -1;
            en_log[k].delete();
            for (int p = 0; p < 2; p++) begin
                ev_ack[k][p] = 0;
                first_ack[k][p] = -1;
            end
        end
    endtask

    task automatic model_reset(input int k);
        m_act[k]  = 1'b0;
        m_last[k] = 1'b1;
        m_addr[k] = '0;
        m_wdata[k] = '0;
        m_rdata[k][0] = '0;
        m_rdata[k][1] = '0;
    endtask

    // evaluated once per cycle, at the falling edge
    task automatic step();
        int   e;
        bit   e_busy, e_en, e_we;
        bit   e_ack [2];
        bit   pick;
        for (int k = 0; k < 2; k++) begin
            if (o_en[k] === 1'b1) begin
                issue_c[k] = cyc;
                issue_a[k] = o_addr[k];
                ev_en[k]++;
                if (first_en[k] < 0) first_en[k] = cyc;
                en_log[k].push_back(o_addr[k]);
                if (o_we[k] === 1'b1) ev_we[k]++;
            end
            if (o_busy[k] === 1'b1) ev_busy[k]++;
            for (int p = 0; p < 2; p++) begin
                ack_seen[k][p] = (o_ack[k][p] === 1'b1);
                if (ack_seen[k][p]) begin
                    ev_ack[k][p]++;
                    if (first_ack[k][p] < 0) first_ack[k][p] = cyc;
                end
            end
            mem_rdata[k] = (cyc == issue_c[k] + lat[k]) ?
                           memval(issue_a[k]) : $urandom;

            e = m_t[k] + 2 + lat[k];
            if (m_valid) begin
                if (m_act[k] && cyc == e) begin
                    if (!m_we[k]) m_rdata[k][m_g[k]] = memval(m_addr[k]);
                    m_last[k] = m_g[k];
                end
                e_busy = m_act[k] && cyc > m_t[k] && cyc <= e;
                e_en   = m_act[k] && cyc == m_t[k] + 1;
                e_we   = e_en && m_we[k];
                e_ack[0] = m_act[k] && cyc == e && m_g[k] == 1'b0;
                e_ack[1] = m_act[k] && cyc == e && m_g[k] == 1'b1;
                chk($sformatf("d%0d busy", k), 32'(o_busy[k]), 32'(e_busy));
                chk($sformatf("d%0d mem_en", k), 32'(o_en[k]), 32'(e_en));
                chk($sformatf("d%0d mem_we", k), 32'(o_we[k]), 32'(e_we));
                chk($sformatf("d%0d mem_addr", k), o_addr[k], m_addr[k]);
                chk($sformatf("d%0d mem_wdata", k), o_wdata[k], m_wdata[k]);
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("d%0d ack%0d", k, p),
                        32'(o_ack[k][p]), 32'(e_ack[p]));
                    chk($sformatf("d%0d rdata%0d", k, p),
                        o_rdata[k][p], m_rdata[k][p]);
                end
            end
            if (rst) begin
                model_reset(k);
            end else if (m_valid && (!m_act[k] || cyc > e) &&
                         (s_req[k][0] || s_req[k][1])) begin
                if (s_req[k][0] && s_req[k][1]) pick = ~m_last[k];
                else                            pick = s_req[k][1];
                m_act[k]   = 1'b1;
                m_t[k]     = cyc;
                m_g[k]     = pick;
                m_we[k]    = s_we[k][pick];
                m_addr[k]  = s_addr[k][pick];
                m_wdata[k] = s_wdata[k][pick];
            end
        end
        if (rst) m_valid = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            s_req[k][p]   = r;
            s_we[k][p]    = w;
            s_addr[k][p]  = a;
            s_wdata[k][p] = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_port(input int k, input int p);
        if (s_req[k][p]) begin
            if (ack_seen[k][p] || $urandom_range(0, 15) == 0)
                s_req[k][p] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            s_req[k][p]   = 1'b1;
            s_we[k][p]    = 1'($urandom_range(0, 1));
            s_addr[k][p]  = 32'($urandom_range(0, 63)) << 2;
            s_wdata[k][p] = $urandom;
        end
    endtask

    int t;

    initial begin
        lat[0] = 1;
        lat[1] = 4;
        cyc = 0;
        rst = 1'b1;
        m_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            issue_c[k] = -100;
            issue_a[k] = '0;
            m_t[k] = -100;
            m_g[k] = 1'b0;
            m_we[k] = 1'b0;
            mem_rdata[k] = '0;
            model_reset(k);
            for (int p = 0; p < 2; p++) begin
                s_req[k][p] = 1'b0;
                s_we[k][p] = 1'b0;
                s_addr[k][p] = '0;
                s_wdata[k][p] = '0;
                ack_seen[k][p] = 1'b0;
            end
        end
        clr_ev();
        do_reset();

        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d rst busy", k), 32'(o_busy[k]), 32'd0);
            chk($sformatf("d%0d rst mem_en", k), 32'(o_en[k]), 32'd0);
            chk($sformatf("d%0d rst mem_addr", k), o_addr[k], 32'd0);
            chk($sformatf("d%0d rst cpu_ack", k), 32'(o_ack[k][0]), 32'd0);
            chk($sformatf("d%0d rst cpu_rdata", k), o_rdata[k][0], 32'd0);
        end

        // CPU read of 0x10, Req dropped in the ISSUE cycle
        clr_ev();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        t = cyc;
        tick();
        drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
        repeat (10) tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d rd en cyc", k), 32'(first_en[k]), 32'(t + 1));
            chk($sformatf("d%0d rd en addr", k), en_log[k][0], 32'h10);
            chk($sformatf("d%0d rd ack cyc", k),
                32'(first_ack[k][0]), 32'(t + 2 + lat[k]));
            chk($sformatf("d%0d rd ack n", k), 32'(ev_ack[k][0]), 32'd1);
            chk($sformatf("d%0d rd dbg ack n", k), 32'(ev_ack[k][1]), 32'd0);
            chk($sformatf("d%0d rd en n", k), 32'(ev_en[k]), 32'd1);
            chk($sformatf("d%0d rd data", k), o_rdata[k][0], 32'hDEADBEEF);
        end
        chk("d0 rd ack lat1", 32'(first_ack[0][0]), 32'(t + 3));

        // debug read of 0x40
        clr_ev();
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
        t = cyc;
        tick();
        drive(1, 1'b0, 1'b0, 32'h40, 32'h0);
        repeat (10) tick();
        chk("d1 dbg ack lat4", 32'(first_ack[1][1]), 32'(t + 6));
        chk("d1 dbg busy n", 32'(ev_busy[1]), 32'd6);
        chk("d0 dbg busy n", 32'(ev_busy[0]), 32'd3);
        for (int k = 0; k < 2; k++)
            chk($sformatf("d%0d dbg rdata", k), o_rdata[k][1], memval(32'h40));

        // CPU read of 0x30, then a debug write of 0x55
        drive(0, 1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        drive(0, 1'b0, 1'b0, 32'h30, 32'h0);
        repeat (10) tick();
        clr_ev();
        drive(1, 1'b1, 1'b1, 32'h44, 32'h55);
        tick();
        drive(1, 1'b0, 1'b1, 32'h44, 32'h55);
        repeat (10) tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d wr cpu rdata", k), o_rdata[k][0], 32'h1234);
            chk($sformatf("d%0d wr dbg rdata", k), o_rdata[k][1], memval(32'h40));
            chk($sformatf("d%0d wr we n", k), 32'(ev_we[k]), 32'd1);
            chk($sformatf("d%0d wr data", k), o_wdata[k], 32'h55);
        end

        // both ports hold writes: CPU wins the first tie after reset
        do_reset();
        clr_ev();
        drive(0, 1'b1, 1'b1, 32'h20, 32'hA0A0_0001);
        drive(1, 1'b1, 1'b1, 32'h24, 32'hB0B0_0002);
        repeat (22) tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d tie n>=3", k), 32'(en_log[k].size() >= 3), 32'd1);
            if (en_log[k].size() >= 3) begin
                chk($sformatf("d%0d tie g0", k), en_log[k][0], 32'h20);
                chk($sformatf("d%0d tie g1", k), en_log[k][1], 32'h24);
                chk($sformatf("d%0d tie g2", k), en_log[k][2], 32'h20);
            end
            chk($sformatf("d%0d tie we n", k), 32'(ev_we[k]), 32'(ev_en[k]));
            chk($sformatf("d%0d tie ack order", k),
                32'(first_ack[k][0] < first_ack[k][1]), 32'd1);
        end

        // reset while dut1 sits in WAIT
        drive(0, 1'b1, 1'b0, 32'h50, 32'h0);
        t = cyc;
        tick();
        drive(0, 1'b0, 1'b0, 32'h50, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("d1 rstw busy", 32'(o_busy[1]), 32'd0);
        chk("d1 rstw mem_en", 32'(o_en[1]), 32'd0);
        clr_ev();
        repeat (10) tick();
        chk("d1 rstw cpu ack n", 32'(ev_ack[1][0]), 32'd0);
        chk("d1 rstw dbg ack n", 32'(ev_ack[1][1]), 32'd0);
        chk("d1 rstw en n", 32'(ev_en[1]), 32'd0);
        chk("d1 rstw rdata", o_rdata[1][0], 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                rand_port(k, 0);
                rand_port(k, 1);
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
